// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flushes and load-use stalls.
// Optional performance counters are built when HAZ_PERFCNT_EN is defined.
module hazard_unit #(
  parameter int AWIDTH      = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] Instr_D,
  input  logic [AWIDTH-1:0] Instr_X,
  input  logic              MemRdX,
  input  logic              RegWEnX,
  input  logic              BrTakenX,
  input  logic              DmemReqM,
  input  logic              DmemRdy,
  output logic              StallF,
  output logic              StallD,
  output logic              StallX,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushX,
  output logic              Err
`ifdef HAZ_PERFCNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_cnt_inc;
  logic [4:0] rs1, rs2, rd;
  logic       mem_wait;
  logic       load_use;
  logic       unused_instr_bits;

  assign rs1          = Instr_D[19:15];
  assign rs2          = Instr_D[24:20];
  assign rd           = Instr_X[11:7];
  assign mem_wait     = DmemReqM && !DmemRdy;
  assign load_use     = MemRdX && RegWEnX && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  assign unused_instr_bits = ^{Instr_D[AWIDTH-1:25], Instr_D[14:0], Instr_X[AWIDTH-1:12], Instr_X[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Branch/load-use hazards are evaluated whenever the pipeline is free to advance,
  // including the cycle in which a memory wait is released.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallX     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushX     = 1'b0;
    Err        = 1'b0;

    unique case (state_q)
      RUN, MEMWAIT: begin
        if (mem_wait) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallX  = 1'b1;
          StallM  = 1'b1;
          state_d = MEMWAIT;
          if (state_q == RUN) begin
            wait_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc == WAIT_LIMIT) begin
              state_d = ERR;
            end
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          if (BrTakenX) begin
            FlushD = 1'b1;
            FlushX = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushX = 1'b1;
          end
        end
      end
      ERR: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallX = 1'b1;
        StallM = 1'b1;
        Err    = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    // Reset bubbles D and X and releases every stall regardless of state.
    if (rst) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallX     = 1'b0;
      StallM     = 1'b0;
      FlushD     = 1'b1;
      FlushX     = 1'b1;
      Err        = 1'b0;
    end
  end

`ifdef HAZ_PERFCNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, StallF};
    flush_cnt_d = flush_cnt_q + {31'd0, FlushX};
    if (rst) begin
      stall_cnt_d = 32'd0;
      flush_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by randomized cycles
// compared against a rule-level reference model.
module tb_hazard_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d, instr_x;
  logic        mem_rd_x, reg_wen_x, br_taken_x, dmem_req_m, dmem_rdy;
  logic        stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, err;
`ifdef HAZ_PERFCNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: sticky error, consecutive wait cycles, event counters.
  bit          m_err   = 1'b0;
  int          m_waits = 0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  always #5 clk = ~clk;

  hazard_unit #(.AWIDTH(32), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .Instr_D  (instr_d),
    .Instr_X  (instr_x),
    .MemRdX   (mem_rd_x),
    .RegWEnX  (reg_wen_x),
    .BrTakenX (br_taken_x),
    .DmemReqM (dmem_req_m),
    .DmemRdy  (dmem_rdy),
    .StallF   (stall_f),
    .StallD   (stall_d),
    .StallX   (stall_x),
    .StallM   (stall_m),
    .FlushD   (flush_d),
    .FlushX   (flush_x),
    .Err      (err)
`ifdef HAZ_PERFCNT_EN
    ,
    .StallCnt (stall_cnt),
    .FlushCnt (flush_cnt)
`endif
  );

  function automatic logic [31:0] makeInstrD(input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] v;
    v        = $urandom;
    v[19:15] = rs1;
    v[24:20] = rs2;
    return v;
  endfunction

  function automatic logic [31:0] makeInstrX(input logic [4:0] rd);
    logic [31:0] v;
    v       = $urandom;
    v[11:7] = rd;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [31:0] d, input logic [31:0] x,
                               input logic mrd, input logic wen, input logic br,
                               input logic req, input logic rdy);
    @(negedge clk);
    rst        = r;
    instr_d    = d;
    instr_x    = x;
    mem_rd_x   = mrd;
    reg_wen_x  = wen;
    br_taken_x = br;
    dmem_req_m = req;
    dmem_rdy   = rdy;
  endtask

  // Expected outputs follow the priority: reset, error, memory wait, branch, load-use.
  task automatic checkOutput(input string tag);
    logic [6:0] expv, obs;
    logic [4:0] rd, rs1, rs2;
    bit         lu;
    #2;
    rd  = instr_x[11:7];
    rs1 = instr_d[19:15];
    rs2 = instr_d[24:20];
    lu  = mem_rd_x && reg_wen_x && (rd != 0) && (rd == rs1 || rd == rs2);
    if (rst)                           expv = 7'b0000_11_0;
    else if (m_err)                    expv = 7'b1111_00_1;
    else if (dmem_req_m && !dmem_rdy)  expv = 7'b1111_00_0;
    else if (br_taken_x)               expv = 7'b0000_11_0;
    else if (lu)                       expv = 7'b1100_01_0;
    else                               expv = 7'b0000_00_0;
    obs = {stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, err};
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed {SF,SD,SX,SM,FD,FX,Err}=%b expected %b", tag, obs, expv);
    end
`ifdef HAZ_PERFCNT_EN
    tests_run++;
    assert (stall_cnt === m_stalls && flush_cnt === m_flushes) else begin
      tests_failed++;
      $error("[TB] FAIL %s_cnt: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
             tag, stall_cnt, flush_cnt, m_stalls, m_flushes);
    end
`endif
    if (rst) begin
      m_err     = 1'b0;
      m_waits   = 0;
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      if (!m_err) begin
        if (dmem_req_m && !dmem_rdy) begin
          m_waits++;
          if (m_waits == TIMEOUT) m_err = 1'b1;
        end else begin
          m_waits = 0;
        end
      end
      m_stalls  = m_stalls + 32'(expv[6]);
      m_flushes = m_flushes + 32'(expv[1]);
    end
  endtask

  initial begin
    logic [31:0] nop_d, nop_x;
    rst = 1'b1; instr_d = '0; instr_x = '0; mem_rd_x = 0; reg_wen_x = 0;
    br_taken_x = 0; dmem_req_m = 0; dmem_rdy = 0;
    nop_d = makeInstrD(5'd1, 5'd2);
    nop_x = makeInstrX(5'd0);

    applyStimulus(1, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("reset");
    applyStimulus(1, nop_d, nop_x, 1, 1, 0, 1, 0); checkOutput("reset_busy");
    applyStimulus(0, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("idle");

    // Load-use on rs2, then the bubble clears it.
    applyStimulus(0, makeInstrD(5'd7, 5'd5), makeInstrX(5'd5), 1, 1, 0, 0, 0); checkOutput("loaduse");
    applyStimulus(0, makeInstrD(5'd7, 5'd5), makeInstrX(5'd5), 0, 1, 0, 0, 0); checkOutput("loaduse_clear");
    applyStimulus(0, makeInstrD(5'd0, 5'd0), makeInstrX(5'd0), 1, 1, 0, 0, 0); checkOutput("x0_load");
    applyStimulus(0, makeInstrD(5'd7, 5'd5), makeInstrX(5'd5), 1, 1, 1, 0, 0); checkOutput("br_over_lu");

    // Memory wait of three cycles with a taken branch that must be ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, nop_d, nop_x, 0, 0, 1, 1, 0); checkOutput("memwait");
    end
    applyStimulus(0, nop_d, nop_x, 0, 0, 0, 1, 1); checkOutput("mem_release");
    applyStimulus(0, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("after_release");

    // Timeout into the sticky error state, then recovery through reset.
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(0, nop_d, nop_x, 0, 0, 0, 1, 0); checkOutput("timeout_wait");
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, nop_d, nop_x, 0, 0, i[0], i[1], 1); checkOutput("err_hold");
    end
    applyStimulus(1, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("err_rst");
    applyStimulus(0, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("after_err_rst");

    // Two load-use events and one branch feed the counters.
    applyStimulus(1, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("perf_rst");
    applyStimulus(0, makeInstrD(5'd3, 5'd9), makeInstrX(5'd3), 1, 1, 0, 0, 0); checkOutput("perf_lu1");
    applyStimulus(0, makeInstrD(5'd3, 5'd9), makeInstrX(5'd3), 0, 1, 0, 0, 0); checkOutput("perf_gap1");
    applyStimulus(0, makeInstrD(5'd8, 5'd9), makeInstrX(5'd9), 1, 1, 0, 0, 0); checkOutput("perf_lu2");
    applyStimulus(0, nop_d, nop_x, 0, 0, 1, 0, 0); checkOutput("perf_br");
    applyStimulus(0, nop_d, nop_x, 0, 0, 0, 0, 0); checkOutput("perf_idle");
`ifdef HAZ_PERFCNT_EN
    tests_run++;
    assert (stall_cnt === 32'd2 && flush_cnt === 32'd3) else begin
      tests_failed++;
      $error("[TB] FAIL perf_totals: observed stall=%0d flush=%0d expected stall=2 flush=3",
             stall_cnt, flush_cnt);
    end
`endif

    // Randomized traffic over a small register range so hazards collide often.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    makeInstrD(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                    makeInstrX(5'($urandom_range(0, 3))),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) < 2));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
